spi_request_arbiter: RTL and testbench

//  Shares the single SPI engine (ADC + DAC targets) among NREQ requesters (port 0 = control unit,

---
 rtl/spi_request_arbiter_pkg.sv | 28 ++
 rtl/spi_request_arbiter_rr_arbiter.sv | 39 +++
 rtl/spi_request_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_spi_request_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_request_arbiter_pkg
// Description : Shared operand widths, target/direction codes and FSM states
//               for the SPI request arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package spi_request_arbiter_pkg;

    localparam int c_addr_w  = 11;
    localparam int c_wdata_w = 12;
    localparam int c_rdata_w = 8;

    localparam logic c_tgt_adc  = 1'b0;
    localparam logic c_tgt_dac  = 1'b1;
    localparam logic c_rw_write = 1'b0;
    localparam logic c_rw_read  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BUSY = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_COMPLETE  = 3'd3,
        ST_ABORT     = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_request_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first set request strictly
//               after the last granted index, wrapping around.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx,
    output logic                    o_grant_valid
);

    localparam int IDX_W = $clog2(NREQ);

    int w_idx;

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        // The last granted slot is visited at offset NREQ, i.e. lowest priority.
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = (int'(i_last) + off) % NREQ;
            if (!o_grant_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
                o_grant_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_request_arbiter
// Description : Shares one SPI engine among NREQ requesters with one-deep
//               slots, round-robin grant, start/busy handshake and timeout.
// Revision    : 1.0  initial release
// ============================================================================
import spi_request_arbiter_pkg::*;

module spi_request_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_target,
    input  logic [NREQ-1:0]           req_rw,
    input  logic [NREQ*c_addr_w-1:0]  req_addr,
    input  logic [NREQ*c_wdata_w-1:0] req_wdata,
    output logic [NREQ-1:0]           req_busy,
    output logic [NREQ-1:0]           req_done,
    output logic [NREQ-1:0]           rd_valid,
    output logic [c_rdata_w-1:0]      rd_data,
    output logic [NREQ-1:0]           err_timeout,
    output logic [NREQ-1:0]           err_overrun,
    input  logic                      err_clear,
    output logic                      spi_start,
    output logic                      spi_target,
    output logic                      spi_rw,
    output logic [c_addr_w-1:0]       spi_addr,
    output logic [c_wdata_w-1:0]      spi_wdata,
    input  logic                      spi_busy,
    input  logic [c_rdata_w-1:0]      spi_rdata
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic [NREQ-1:0]                r_slot_busy;
    logic [NREQ-1:0]                r_slot_target;
    logic [NREQ-1:0]                r_slot_rw;
    logic [NREQ-1:0][c_addr_w-1:0]  r_slot_addr;
    logic [NREQ-1:0][c_wdata_w-1:0] r_slot_wdata;

    logic [NREQ-1:0]      r_grant_oh;
    logic [IDX_W-1:0]     r_last;
    logic [TMR_W-1:0]     r_timer;
    logic [c_rdata_w-1:0] r_rdata;
    logic                 r_spi_start;
    logic                 r_spi_target;
    logic                 r_spi_rw;
    logic [c_addr_w-1:0]  r_spi_addr;
    logic [c_wdata_w-1:0] r_spi_wdata;
    logic [NREQ-1:0]      r_err_timeout;
    logic [NREQ-1:0]      r_err_overrun;

    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_grant_valid;
    logic             w_grant_dac_read;
    logic             w_do_grant;
    logic             w_finishing;
    logic [NREQ-1:0]  w_release;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .i_req         (r_slot_busy),
        .i_last        (r_last),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign w_grant_dac_read = (r_slot_target[w_grant_idx] == c_tgt_dac) &&
                              (r_slot_rw[w_grant_idx] == c_rw_read);
    assign w_do_grant       = (r_state == ST_IDLE) && w_grant_valid;
    assign w_finishing      = (r_state == ST_COMPLETE) || (r_state == ST_ABORT);
    assign w_release        = w_finishing ? r_grant_oh : '0;

    always_comb begin
        w_state_next = r_state;
        req_done     = '0;
        rd_valid     = '0;
        rd_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid)
                    w_state_next = w_grant_dac_read ? ST_COMPLETE : ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy)
                    w_state_next = ST_WAIT_DONE;
                else if (r_timer == c_tmr_last)
                    w_state_next = ST_ABORT;
            end
            ST_WAIT_DONE: begin
                if (!spi_busy)
                    w_state_next = ST_COMPLETE;
                else if (r_timer == c_tmr_last)
                    w_state_next = ST_ABORT;
            end
            ST_COMPLETE: begin
                w_state_next = ST_IDLE;
                req_done     = r_grant_oh;
                if (r_spi_rw == c_rw_read) begin
                    rd_valid = r_grant_oh;
                    rd_data  = r_rdata;
                end
            end
            ST_ABORT: begin
                w_state_next = ST_IDLE;
                req_done     = r_grant_oh;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            // Every state entry restarts the timer; it saturates otherwise.
            if (w_state_next != r_state)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + 1'b1;
        end
    end

    // A slot being released this cycle still counts as busy for new requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_busy   <= '0;
            r_slot_target <= '0;
            r_slot_rw     <= '0;
            r_slot_addr   <= '0;
            r_slot_wdata  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !r_slot_busy[i]) begin
                    r_slot_busy[i]   <= 1'b1;
                    r_slot_target[i] <= req_target[i];
                    r_slot_rw[i]     <= req_rw[i];
                    r_slot_addr[i]   <= req_addr[i*c_addr_w +: c_addr_w];
                    r_slot_wdata[i]  <= req_wdata[i*c_wdata_w +: c_wdata_w];
                end else if (w_release[i]) begin
                    r_slot_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_oh   <= '0;
            r_last       <= IDX_W'(NREQ - 1);
            r_rdata      <= '0;
            r_spi_start  <= 1'b0;
            r_spi_target <= 1'b0;
            r_spi_rw     <= 1'b0;
            r_spi_addr   <= '0;
            r_spi_wdata  <= '0;
        end else begin
            r_spi_start <= 1'b0;
            if (w_do_grant) begin
                r_grant_oh   <= w_grant;
                r_last       <= w_grant_idx;
                r_rdata      <= '0;
                r_spi_start  <= !w_grant_dac_read;
                r_spi_target <= r_slot_target[w_grant_idx];
                r_spi_rw     <= r_slot_rw[w_grant_idx];
                r_spi_addr   <= r_slot_addr[w_grant_idx];
                r_spi_wdata  <= r_slot_wdata[w_grant_idx];
            end
            if ((r_state == ST_WAIT_DONE) && !spi_busy)
                r_rdata <= spi_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_timeout <= '0;
            r_err_overrun <= '0;
        end else begin
            r_err_overrun <= (err_clear ? '0 : r_err_overrun) | (req_valid & r_slot_busy);
            r_err_timeout <= (err_clear ? '0 : r_err_timeout) |
                             ((w_state_next == ST_ABORT && r_state != ST_ABORT) ? r_grant_oh : '0);
        end
    end

    assign req_busy    = r_slot_busy;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;
    assign spi_start   = r_spi_start;
    assign spi_target  = r_spi_target;
    assign spi_rw      = r_spi_rw;
    assign spi_addr    = r_spi_addr;
    assign spi_wdata   = r_spi_wdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_request_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_request_arbiter
// Description : Directed self-checking bench for spi_request_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_request_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid, req_target, req_rw;
    logic [NREQ*11-1:0] req_addr;
    logic [NREQ*12-1:0] req_wdata;
    logic [NREQ-1:0]   req_busy, req_done, rd_valid, err_timeout, err_overrun;
    logic [7:0]        rd_data;
    logic              err_clear;
    logic              spi_start, spi_target, spi_rw, spi_busy;
    logic [10:0]       spi_addr;
    logic [11:0]       spi_wdata;
    logic [7:0]        spi_rdata;

    always #5 clk = ~clk;

    spi_request_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_target  (req_target),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_busy    (req_busy),
        .req_done    (req_done),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_clear   (err_clear),
        .spi_start   (spi_start),
        .spi_target  (spi_target),
        .spi_rw      (spi_rw),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_busy    (spi_busy),
        .spi_rdata   (spi_rdata)
    );

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_done [NREQ] = '{default: 0};
    int n_rdv  [NREQ] = '{default: 0};
    logic [7:0] last_rd = 8'h00;
    int done_q [$];

    // Pulse monitor; the stimulus samples 1 ns after this runs.
    always @(negedge clk) begin
        if (spi_start) n_start++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_done[i]) begin
                n_done[i]++;
                done_q.push_back(i);
            end
            if (rd_valid[i]) begin
                n_rdv[i]++;
                last_rd = rd_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic tgt, input logic rw,
                           input logic [10:0] a, input logic [11:0] d);
        req_target[idx]       = tgt;
        req_rw[idx]           = rw;
        req_addr[idx*11 +: 11] = a;
        req_wdata[idx*12 +: 12] = d;
    endtask

    task automatic pulse(input logic [NREQ-1:0] mask);
        req_valid = mask;
        tick();
        req_valid = '0;
    endtask

    task automatic wait_start(input string tag);
        int c = 0;
        while (!spi_start && c < 30) begin
            tick();
            c++;
        end
        chk({tag, "_start_seen"}, 32'(spi_start), 32'd1);
    endtask

    task automatic serve(input string tag, input logic [10:0] ea, input logic [11:0] ew,
                         input logic et, input logic erw, input int dly, input int len,
                         input logic [7:0] rdata);
        wait_start(tag);
        chk({tag, "_addr"},   32'(spi_addr),   32'(ea));
        chk({tag, "_wdata"},  32'(spi_wdata),  32'(ew));
        chk({tag, "_target"}, 32'(spi_target), 32'(et));
        chk({tag, "_rw"},     32'(spi_rw),     32'(erw));
        tick(dly);
        spi_busy = 1'b1;
        tick(len);
        spi_rdata = rdata;
        spi_busy  = 1'b0;
        tick();
    endtask

    initial begin
        int c;
        int k;
        int nst;
        int d0;
        int r0;

        reset_n    = 1'b0;
        req_valid  = '0;
        req_target = '0;
        req_rw     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        err_clear  = 1'b0;
        spi_busy   = 1'b0;
        spi_rdata  = '0;
        tick(2);
        chk("rst_req_busy",  32'(req_busy),    32'd0);
        chk("rst_req_done",  32'(req_done),    32'd0);
        chk("rst_spi_start", 32'(spi_start),   32'd0);
        chk("rst_errors",    32'({err_timeout, err_overrun}), 32'd0);
        chk("rst_spi_addr",  32'(spi_addr),    32'd0);
        reset_n = 1'b1;
        tick();

        // 1: ADC write from requester 0
        set_req(0, 1'b0, 1'b0, 11'h123, 12'h0A5);
        pulse(2'b01);
        chk("t1_busy_after_accept", 32'(req_busy), 32'b01);
        serve("t1", 11'h123, 12'h0A5, 1'b0, 1'b0, 3, 5, 8'h00);
        tick(2);
        chk("t1_starts",  32'(n_start),  32'd1);
        chk("t1_done0",   32'(n_done[0]), 32'd1);
        chk("t1_no_rdv",  32'(n_rdv[0]),  32'd0);
        chk("t1_idle",    32'(req_busy),  32'd0);

        // 2: ADC read from requester 1
        set_req(1, 1'b0, 1'b1, 11'h010, 12'h000);
        pulse(2'b10);
        serve("t2", 11'h010, 12'h000, 1'b0, 1'b1, 4, 6, 8'h3C);
        tick(2);
        chk("t2_rdv1",   32'(n_rdv[1]),  32'd1);
        chk("t2_rddata", 32'(last_rd),   32'h3C);
        chk("t2_done1",  32'(n_done[1]), 32'd1);
        chk("t2_starts", 32'(n_start),   32'd2);

        // 3: simultaneous requests and re-requests alternate 0,1,0,1
        done_q.delete();
        set_req(0, 1'b0, 1'b0, 11'h0AA, 12'h111);
        set_req(1, 1'b0, 1'b0, 11'h155, 12'h222);
        pulse(2'b11);
        serve("t3a", 11'h0AA, 12'h111, 1'b0, 1'b0, 3, 2, 8'h00);
        tick();
        pulse(2'b01);
        serve("t3b", 11'h155, 12'h222, 1'b0, 1'b0, 3, 2, 8'h00);
        tick();
        pulse(2'b10);
        serve("t3c", 11'h0AA, 12'h111, 1'b0, 1'b0, 3, 2, 8'h00);
        tick();
        serve("t3d", 11'h155, 12'h222, 1'b0, 1'b0, 3, 2, 8'h00);
        tick(2);
        chk("t3_done_count", 32'(done_q.size()), 32'd4);
        if (done_q.size() == 4) begin
            chk("t3_order0", 32'(done_q[0]), 32'd0);
            chk("t3_order1", 32'(done_q[1]), 32'd1);
            chk("t3_order2", 32'(done_q[2]), 32'd0);
            chk("t3_order3", 32'(done_q[3]), 32'd1);
        end
        chk("t3_no_overrun", 32'(err_overrun), 32'd0);
        chk("t3_idle",       32'(req_busy),    32'd0);

        // 4: DAC read completes without SPI traffic
        nst = n_start;
        r0  = n_rdv[0];
        d0  = n_done[0];
        set_req(0, 1'b1, 1'b1, 11'h005, 12'hFFF);
        pulse(2'b01);
        c = 0;
        while (n_rdv[0] == r0 && c < 6) begin
            tick();
            c++;
        end
        chk("t4_latency_ok", 32'(c >= 1 && c <= 3), 32'd1);
        chk("t4_rdv0",       32'(n_rdv[0]),  32'(r0 + 1));
        chk("t4_rddata",     32'(last_rd),   32'h00);
        chk("t4_done0",      32'(n_done[0]), 32'(d0 + 1));
        chk("t4_no_start",   32'(n_start),   32'(nst));
        tick(2);

        // 5: engine never answers -> timeout abort
        r0 = n_rdv[0];
        set_req(0, 1'b0, 1'b0, 11'h200, 12'h055);
        pulse(2'b01);
        wait_start("t5");
        d0 = n_done[0];
        k  = 0;
        while (n_done[0] == d0 && k < 40) begin
            tick();
            k++;
        end
        chk("t5_abort_delay", 32'(k),           32'd16);
        chk("t5_err_timeout", 32'(err_timeout), 32'b01);
        chk("t5_no_rdv",      32'(n_rdv[0]),    32'(r0));
        tick();
        chk("t5_slot_free",   32'(req_busy),    32'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t5_err_cleared", 32'(err_timeout), 32'd0);

        // 6: overrun while busy, then reset mid-transfer
        nst = n_start;
        d0  = n_done[0];
        r0  = n_rdv[0];
        set_req(0, 1'b0, 1'b1, 11'h077, 12'h000);
        pulse(2'b01);
        wait_start("t6");
        tick();
        pulse(2'b01);
        chk("t6_err_overrun", 32'(err_overrun), 32'b01);
        spi_busy = 1'b1;
        tick(2);
        chk("t6_one_start", 32'(n_start - nst), 32'd1);
        chk("t6_busy_pre_rst", 32'(req_busy), 32'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_req_busy", 32'(req_busy),    32'd0);
        chk("t6_rst_overrun",  32'(err_overrun), 32'd0);
        chk("t6_rst_spi_addr", 32'(spi_addr),    32'd0);
        chk("t6_rst_spi_rw",   32'(spi_rw),      32'd0);
        chk("t6_rst_done",     32'(req_done),    32'd0);
        spi_busy = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        chk("t6_no_done_after", 32'(n_done[0]), 32'(d0));
        chk("t6_no_rdv_after",  32'(n_rdv[0]),  32'(r0));
        chk("t6_no_new_start",  32'(n_start),   32'(nst + 1));
        chk("t6_idle",          32'(req_busy),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
